muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit on the execute side of the core, directly downstream of the register file.
- Consumes the RD1/RD2 operand values and produces a writeback triple (we, rd_addr, wd) that drives the register file WE3/A3/WD3 ports.
- Stalls the core through busy while it computes over multiple cycles.

Parameters:
- XLEN, 32, operand and result width.
- REG_ADDR_W, 5, destination register address width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- op  in  3  RV32M funct3 encoding.
- rs1_val  in  XLEN  dividend / multiplicand (from RD1).
- rs2_val  in  XLEN  divisor / multiplier (from RD2).
- rd_in  in  REG_ADDR_W  destination register.
- busy  out  1  high from the cycle after start acceptance through the DONE cycle.
- done  out  1  one-cycle completion pulse.
- we  out  1  register write enable (to WE3).
- rd_addr  out  REG_ADDR_W  write address (to A3).
- wd  out  XLEN  write data (to WD3).

Behaviour:
- Reset (rst=0, any time, including mid-operation):
  - state goes to IDLE.
  - busy, done, we, rd_addr, wd, counter and all datapath registers are 0.
  - No writeback is issued for an aborted operation.
- States and transitions:
  - IDLE -> CALC on start=1.
  - IDLE -> DONE on start=1 for special cases (see below).
  - CALC -> DONE after 32 iterations.
  - DONE -> IDLE unconditionally.
- Acceptance: when start is sampled in IDLE, op, rs1_val, rs2_val and rd_in are registered. Inputs may change afterwards.
- Timing, with start sampled at the end of cycle 0:
  - Normal op: CALC in cycles 1..32 (5-bit counter 0..31), DONE in cycle 33.
  - Special case: DONE in cycle 1.
  - busy=1 in cycles 1..DONE inclusive; IDLE again the cycle after DONE, when a new start may be accepted.
  - start while busy=1 (including in DONE) is ignored, with no queueing.
- DONE cycle:
  - done=1 and rd_addr/wd are valid.
  - we=1 unless rd_in==0, in which case we=0 (x0 is never written) while done still pulses.
- After DONE: we and done return to 0; rd_addr and wd hold their values until the next acceptance.
- Multiply (MUL=000, MULH=001, MULHSU=010, MULHU=011):
  - Operands are converted to magnitudes. rs1 is treated as signed for MUL/MULH/MULHSU; rs2 as signed for MUL/MULH.
  - 32-step shift-add produces an unsigned 64-bit product, negated if the operand signs differ.
  - MUL returns bits [31:0]; the others return [63:32].
- Divide (DIV=100, DIVU=101, REM=110, REMU=111):
  - 32-step restoring division on magnitudes.
  - Signed: quotient negated when the operand signs differ; remainder takes the sign of the dividend.
- Special cases (resolved in 1 cycle, no CALC):
  - Divisor 0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return rs1_val.
  - Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined: the four multiply ops use a single-cycle combinational 64-bit product and go IDLE -> DONE, so done is in cycle 1. Divide timing is unchanged.
- Undefined: all multiplies use the 32-cycle iterative path, with DONE in cycle 33.

Decomposition:
- Package muldiv_pkg holds:
  - op encoding constants MD_MUL..MD_REMU;
  - state encoding IDLE/CALC/DONE;
  - XLEN default and ITER_CNT_W=5;
  - special-case constants DIV0_QUOT=all-ones and OVF_QUOT=0x80000000.
- One sub-module, muldiv_sign_fix: combinational conditional abs/negate, instanced for operand conditioning and for result correction.

Test Plan:
- MUL 7 x 0xFFFFFFFD (-3), rd=5 -> done and we in cycle 33, rd_addr=5, wd=0xFFFFFFEB; busy high cycles 1..33. With MULDIV_FAST_MUL_EN: same result, done in cycle 1.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIVU 100/7 -> 14 and REMU -> 2, done in cycle 33; REM 0xFFFFFFF9 (-7)/2 -> 0xFFFFFFFF; DIV -7/2 -> 0xFFFFFFFD.
- DIV 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, both with done in cycle 1; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0, done in cycle 1.
- Second start pulsed in cycle 10 of a DIVU -> ignored (single done in cycle 33, original result); rd_in=0 -> done=1, we=0.
- rst driven low in cycle 10 of a MUL -> busy, done, we and wd are 0 immediately; no later done; a new start after reset release completes normally.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: op encodings,
// FSM states, iteration counter width and special-case result constants.
package muldiv_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int ITER_CNT_W   = 5;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } md_state_e;

  localparam logic [XLEN_DEFAULT-1:0] DIV0_QUOT = '1;
  localparam logic [XLEN_DEFAULT-1:0] OVF_QUOT  = {1'b1, {(XLEN_DEFAULT-1){1'b0}}};

  // rs1 is signed for MUL/MULH/MULHSU/DIV/REM
  function automatic logic op_a_signed(input md_op_e f);
    return (f == MD_MUL) || (f == MD_MULH) || (f == MD_MULHSU) ||
           (f == MD_DIV) || (f == MD_REM);
  endfunction

  // rs2 is signed for MUL/MULH/DIV/REM
  function automatic logic op_b_signed(input md_op_e f);
    return (f == MD_MUL) || (f == MD_MULH) || (f == MD_DIV) || (f == MD_REM);
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate. Used both to take magnitudes of
// signed operands and to restore the sign of the final result.
module muldiv_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);

  assign res = neg ? (~val + W'(1)) : val;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with register-file writeback.
// Optional macro MULDIV_FAST_MUL_EN: multiplies complete in one cycle
// through a combinational product; divides stay iterative.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN       = XLEN_DEFAULT,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [XLEN-1:0]       rs1_val,
  input  logic [XLEN-1:0]       rs2_val,
  input  logic [REG_ADDR_W-1:0] rd_in,
  output logic                  busy,
  output logic                  done,
  output logic                  we,
  output logic [REG_ADDR_W-1:0] rd_addr,
  output logic [XLEN-1:0]       wd
);

  localparam logic [XLEN-1:0] Q_DIV0 = XLEN'(DIV0_QUOT);
  localparam logic [XLEN-1:0] Q_OVF  = XLEN'(OVF_QUOT);

  md_state_e             state, state_nxt;
  md_op_e                op_in, op_q, op_sel;
  logic [ITER_CNT_W-1:0] cnt;
  logic [2*XLEN-1:0]     acc, acc_nxt, raw, prod_fix;
  logic [XLEN-1:0]       opb;
  logic                  neg_q, neg_r, nq_sel, nr_sel;

  logic                  a_sgn, b_sgn, is_div, is_rem, div0, ovf;
  logic                  spec_hit, fast_path;
  logic [XLEN-1:0]       a_mag, b_mag, spec_val;
  logic [XLEN-1:0]       quo_fix, rem_fix, result;

  logic [XLEN:0]         mul_sum, rem_sh;
  logic [XLEN-1:0]       div_diff;
  logic                  div_ge;

  assign op_in    = md_op_e'(op);
  assign a_sgn    = op_a_signed(op_in) & rs1_val[XLEN-1];
  assign b_sgn    = op_b_signed(op_in) & rs2_val[XLEN-1];
  assign is_div   = op_in[2];
  assign is_rem   = op_in[1];
  assign div0     = (rs2_val == '0);
  assign ovf      = ((op_in == MD_DIV) || (op_in == MD_REM)) &&
                    (rs1_val == Q_OVF) && (rs2_val == '1);
  assign spec_hit = is_div && (div0 || ovf);
  assign spec_val = div0 ? (is_rem ? rs1_val : Q_DIV0) : (is_rem ? '0 : Q_OVF);

`ifdef MULDIV_FAST_MUL_EN
  assign fast_path = !op_in[2];
`else
  assign fast_path = 1'b0;
`endif

  muldiv_sign_fix #(.W(XLEN)) u_abs_a (.val(rs1_val), .neg(a_sgn), .res(a_mag));
  muldiv_sign_fix #(.W(XLEN)) u_abs_b (.val(rs2_val), .neg(b_sgn), .res(b_mag));

  // One shift-add (multiply) or restoring-subtract (divide) step on acc.
  // Multiply: acc = {partial_hi, multiplier}, opb = multiplicand.
  // Divide:   acc = {remainder, dividend/quotient}, opb = divisor.
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opb & {XLEN{acc[0]}}};
    rem_sh   = acc[2*XLEN-1:XLEN-1];
    // rem_sh - opb always fits XLEN bits when the subtract is taken
    div_ge   = rem_sh[XLEN] | (rem_sh[XLEN-1:0] >= opb);
    div_diff = rem_sh[XLEN-1:0] - opb;
    if (op_q[2]) begin
      acc_nxt = div_ge ? {div_diff, acc[XLEN-2:0], 1'b1} : {acc[2*XLEN-2:0], 1'b0};
    end else begin
      acc_nxt = {mul_sum, acc[XLEN-1:1]};
    end
  end

  // Select the raw 64-bit value and sign flags feeding result correction:
  // live inputs while IDLE (fast multiply), registered state otherwise.
  always_comb begin
    op_sel = op_q;
    nq_sel = neg_q;
    nr_sel = neg_r;
    raw    = acc_nxt;
    if (state == IDLE) begin
      op_sel = op_in;
      nq_sel = a_sgn ^ b_sgn;
      nr_sel = a_sgn;
`ifdef MULDIV_FAST_MUL_EN
      raw    = a_mag * b_mag;
`endif
    end
  end

  muldiv_sign_fix #(.W(2*XLEN)) u_fix_prod (.val(raw), .neg(nq_sel), .res(prod_fix));
  muldiv_sign_fix #(.W(XLEN)) u_fix_quo (.val(raw[XLEN-1:0]), .neg(nq_sel), .res(quo_fix));
  muldiv_sign_fix #(.W(XLEN)) u_fix_rem (.val(raw[2*XLEN-1:XLEN]), .neg(nr_sel), .res(rem_fix));

  // Pick the architectural result for the op
  always_comb begin
    result = rem_fix;
    case (op_sel)
      MD_MUL:                       result = prod_fix[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: result = prod_fix[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              result = quo_fix;
      default:                      result = rem_fix;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (spec_hit || fast_path) ? DONE : CALC;
      CALC:    if (cnt == '1) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, iteration and writeback data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q    <= MD_MUL;
      cnt     <= '0;
      acc     <= '0;
      opb     <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      rd_addr <= '0;
      wd      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q    <= op_in;
            rd_addr <= rd_in;
            neg_q   <= a_sgn ^ b_sgn;
            neg_r   <= a_sgn;
            cnt     <= '0;
            acc     <= {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
            opb     <= is_div ? b_mag : a_mag;
            if (spec_hit)       wd <= spec_val;
            else if (fast_path) wd <= result;
          end
        end
        CALC: begin
          acc <= acc_nxt;
          cnt <= cnt + ITER_CNT_W'(1);
          if (cnt == '1) wd <= result;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign we   = done && (rd_addr != '0);

endmodule
